// File: rtl/gate_test_pkg.sv
// Shared definitions for the gate self-test slice: FSM state encoding and
// default vector width, feedback polynomial and seed used by stimulus and response blocks.
package gate_test_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } state_t;

  localparam int unsigned GATE_W    = 4;
  localparam logic [3:0]  GATE_POLY = 4'b0011;
  localparam logic [3:0]  GATE_SEED = 4'h0;

endpackage

// File: rtl/gate_response_misr_if.sv
// Sample/report bundle between a gate response compactor and whoever drives it.
interface gate_response_misr_if #(
  parameter int unsigned W = 4
);
  logic         start;
  logic         busy;
  logic         x_valid;
  logic [W-1:0] x_in;
  logic         done;
  logic [W-1:0] signature;
  logic         pass;
  logic         timeout;

  modport master (
    output start, x_valid, x_in,
    input  busy, done, signature, pass, timeout
  );

  modport slave (
    input  start, x_valid, x_in,
    output busy, done, signature, pass, timeout
  );
endinterface

// File: rtl/gate_response_misr_core.sv
// Multiple-input signature register: shift with polynomial feedback, XOR in d when en.
// load (or rst) forces the register to seed.
module misr_core
  import gate_test_pkg::*;
#(
  parameter int unsigned    W    = GATE_W,
  parameter logic [W-1:0]   POLY = W'(GATE_POLY)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] seed,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] sig
);

  logic [W-1:0] sig_next;

  always_comb begin
    sig_next = {sig[W-2:0], 1'b0} ^ (sig[W-1] ? POLY : '0) ^ d;
  end

  always_ff @(posedge clk) begin
    if (rst || load) begin
      sig <= seed;
    end else if (en) begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/gate_response_misr.sv
// Compacts NUM_SAMPLES gate outputs into a MISR signature and flags pass against GOLDEN.
// Optional idle-timeout abort enabled by defining GATE_RESPONSE_MISR_TIMEOUT_EN.
module gate_response_misr
  import gate_test_pkg::*;
#(
  parameter int unsigned  W           = GATE_W,
  parameter int unsigned  NUM_SAMPLES = 8,
  parameter logic [W-1:0] POLY        = W'(GATE_POLY),
  parameter logic [W-1:0] SEED        = W'(GATE_SEED),
  parameter logic [W-1:0] GOLDEN      = '0,
  parameter int unsigned  TIMEOUT     = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  gate_response_misr_if.slave  bus
);

  localparam int unsigned CW = $clog2(NUM_SAMPLES + 1);

  state_t        state;
  logic [CW-1:0] count;
  logic          busy_q;
  logic          done_q;
  logic          pass_q;
  logic          timeout_q;
  logic [W-1:0]  sig;
  logic [W-1:0]  sig_next;
  logic          start_ok;
  logic          accept;
  logic          last;

  assign start_ok = bus.start && (state != COLLECT);
  assign accept   = bus.x_valid && (state == COLLECT);
  assign last     = accept && (count == CW'(NUM_SAMPLES - 1));

  // Same step as the core; pass must be registered at the edge that absorbs the final sample.
  always_comb begin
    sig_next = {sig[W-2:0], 1'b0} ^ (sig[W-1] ? POLY : '0) ^ bus.x_in;
  end

  misr_core #(
    .W    (W),
    .POLY (POLY)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .load (start_ok),
    .seed (SEED),
    .en   (accept),
    .d    (bus.x_in),
    .sig  (sig)
  );

`ifdef GATE_RESPONSE_MISR_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
`ifdef GATE_RESPONSE_MISR_TIMEOUT_EN
      idle_cnt  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state     <= COLLECT;
            count     <= '0;
            busy_q    <= 1'b1;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
`ifdef GATE_RESPONSE_MISR_TIMEOUT_EN
            idle_cnt  <= '0;
`endif
          end
        end
        COLLECT: begin
          if (accept) begin
            count <= count + 1'b1;
`ifdef GATE_RESPONSE_MISR_TIMEOUT_EN
            idle_cnt <= '0;
`endif
            if (last) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              pass_q <= (sig_next == GOLDEN);
            end
          end
`ifdef GATE_RESPONSE_MISR_TIMEOUT_EN
          // Abort on the edge that would bring the idle count up to TIMEOUT.
          else if (idle_cnt == TW'(TIMEOUT - 1)) begin
            state     <= DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            pass_q    <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.signature = sig;
`ifdef GATE_RESPONSE_MISR_TIMEOUT_EN
  assign bus.timeout   = timeout_q;
`else
  assign bus.timeout   = 1'b0;
`endif

endmodule

// File: doc/gate_response_misr.md
Name: gate_response_misr

Overview:
- Response-side counterpart to the gate stimulus sequence: samples the W-bit output vector of a combinational gate block under test and compacts it into a multiple-input signature register (MISR).
- Runs for a programmed number of accepted samples, then reports the signature and a pass/fail against a golden value.
- Sits beside the gate DUT for synthesizable self-test and lets benches check a whole vector sweep with one compare.

Parameters:
- W, 4, width of sampled vector and signature.
- NUM_SAMPLES, 8, accepted samples per run (>=1).
- POLY, 4'b0011, feedback taps (x^4+x+1 for W=4), W bits.
- SEED, 0, signature value at reset and at start.
- GOLDEN, 0, expected final signature, W bits.
- TIMEOUT, 255, idle cycles tolerated between samples (used only with the optional feature, >=1).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a run; honoured only in IDLE/DONE.
- busy  out  1  high while collecting.
- x_valid  in  1  x_in valid this cycle.
- x_in  in  W  DUT output vector.
- done  out  1  one-cycle pulse at end of run.
- signature  out  W  current/final MISR value.
- pass  out  1  signature==GOLDEN, valid from done until next start.
- timeout  out  1  run aborted by timeout; tied 0 without the macro.

Behaviour:
- Reset (sync, rst=1 at clk edge): state=IDLE, signature=SEED, count=0, busy=0, done=0, pass=0, timeout=0. Reset mid-run aborts with no done pulse.
- States: IDLE -> COLLECT on start. COLLECT -> DONE after the NUM_SAMPLES-th accepted sample. DONE -> COLLECT on start; otherwise DONE holds.
- On a start edge: signature<=SEED, count<=0, pass<=0, timeout<=0, busy<=1.
- A sample in the same cycle as start is ignored, because busy is not yet high.
- Sample acceptance: x_valid && state==COLLECT.
- Update rule: sig_next = ({sig[W-2:0],1'b0} ^ (sig[W-1] ? POLY : 0)) ^ x_in.
- count increments per accepted sample. Width is $clog2(NUM_SAMPLES+1).
- Final sample accepted at edge N. At edge N:
  - state=DONE, busy=0;
  - signature holds the final value;
  - done=1 for exactly one cycle, during the cycle after edge N.
- pass is registered at the same edge as done, from the final signature, and holds until the next start.
- x_valid outside COLLECT is ignored and the signature does not change.
- start while in COLLECT is ignored; the run continues.
- Gaps in x_valid are allowed. The count only advances on accepted samples.
- signature is visible every cycle (the running value) and freezes in IDLE and DONE.

Optional Feature:
- Macro: GATE_RESPONSE_MISR_TIMEOUT_EN.
- Defined:
  - An idle counter clears on each accepted sample and on start, and increments each COLLECT cycle without x_valid.
  - When it reaches TIMEOUT, the block goes to DONE with done pulse, timeout=1 and pass=0. signature holds the partial value.
  - timeout clears on the next start.
- Undefined: no idle counter; timeout is constant 0; COLLECT waits indefinitely.

Decomposition:
- Shared package gate_test_pkg:
  - state enum {IDLE, COLLECT, DONE};
  - default W, POLY and SEED constants, reused by the stimulus generator.
- One natural sub-module: misr_core (W, POLY). Inputs: clk, rst, load, seed, en, d. Output: sig.
- The control FSM, counters and compare stay in the top.

Test Plan:
- Reset check: rst held 2 cycles, then released -> busy=0, done=0, pass=0, timeout=0, signature=4'h0.
- Basic run: NUM_SAMPLES=3, start, x_in 3,5,1 on consecutive x_valid cycles.
  - Running signature 3 -> 3 -> 7.
  - done pulses one cycle after third sample, with signature=4'h7.
  - GOLDEN=7 gives pass=1.
- Feedback path: NUM_SAMPLES=4, four samples of 4'hF with gaps of 0-3 idle cycles.
  - Signature F -> 2 -> B -> A; final 4'hA.
  - With GOLDEN=0, pass=0.
- Ignored inputs: start and x_valid together in IDLE -> sample not absorbed. Also verify:
  - start mid-COLLECT is ignored;
  - x_valid in DONE leaves signature unchanged;
  - a second start reloads SEED and clears pass.
- Reset mid-run: rst after 2 of 3 samples -> IDLE, signature=SEED, no done pulse. A fresh run with 3,5,1 then gives 4'h7.
- Timeout (macro defined, TIMEOUT=5): start, one sample 3, then no x_valid -> done pulses after 5 idle cycles, with timeout=1, pass=0, signature=4'h3.
